// File: rtl/or_gate_pkg.sv
// Shared defaults and helpers for the or_gate block.
// Provides the default hit-counter width and the saturating increment used by or_gate_satcnt.
package or_gate_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned SAT_MAX_W     = 64;

    // Adds one to value, but never goes past the all-ones value of a width-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] value,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] max_val;
        max_val = (width >= SAT_MAX_W) ? '1
                                       : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
        return (value >= max_val) ? max_val : value + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/or_gate_satcnt.sv
// Saturating hit counter for or_gate.
// Counts up on inc and holds at all-ones; synchronous active-high reset.
module or_gate_satcnt
    import or_gate_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= CNT_W'(sat_inc(SAT_MAX_W'(count), CNT_W));
        end
    end

endmodule

// File: rtl/or_gate.sv
// Registered three-input OR with valid tracking and a saturating hit counter.
// Optional sticky accumulator is built only when OR_GATE_STICKY_EN is defined.
module or_gate
    import or_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic             in_valid,
`ifdef OR_GATE_STICKY_EN
    input  logic             sticky_clr,
    output logic [WIDTH-1:0] sticky,
`endif
    output logic [WIDTH-1:0] p,
    output logic             p_any,
    output logic             p_valid,
    output logic [CNT_W-1:0] hit_count
);

    logic             accept_c;
    logic [WIDTH-1:0] or_val_c;
    logic             any_c;

    assign accept_c = in_valid & ~rst;
    assign or_val_c = x | y | z;
    assign any_c    = |or_val_c;

    // Result registers load only on an accepted sample; p_valid simply tracks in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            p       <= '0;
            p_any   <= 1'b0;
            p_valid <= 1'b0;
        end else begin
            p_valid <= in_valid;
            if (in_valid) begin
                p     <= or_val_c;
                p_any <= any_c;
            end
        end
    end

    or_gate_satcnt #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept_c & any_c),
        .count (hit_count)
    );

`ifdef OR_GATE_STICKY_EN
    // A clear restarts accumulation from the current accepted sample, if any.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= '0;
        end else if (sticky_clr) begin
            sticky <= in_valid ? or_val_c : '0;
        end else if (in_valid) begin
            sticky <= sticky | or_val_c;
        end
    end
`endif

endmodule

// File: tb/tb_or_gate.sv
// Scoreboard bench for or_gate: three instances (WIDTH/CNT_W = 1/16, 4/2, 8/16) driven in lockstep.
// Define OR_GATE_STICKY_EN to also exercise the sticky accumulator.
module tb_or_gate;

    typedef struct packed {
        logic [7:0]  p;
        logic        any;
        logic        pv;
        logic [15:0] hc;
        logic [7:0]  st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] xi = '0, yi = '0, zi = '0;
    logic       vi = 1'b0;
    logic       sticky_clr = 1'b0;

    logic        p1, any1, pv1;
    logic [15:0] hc1;
    logic [3:0]  p4;
    logic        any4, pv4;
    logic [1:0]  hc4;
    logic [7:0]  p8;
    logic        any8, pv8;
    logic [15:0] hc8;
    logic        st1;
    logic [3:0]  st4;
    logic [7:0]  st8;

    int n_pass  = 0;
    int n_total = 0;

    exp_t exp_q[$];
    logic [7:0]  m_p   [3] = '{8'h00, 8'h00, 8'h00};
    logic        m_any [3] = '{1'b0, 1'b0, 1'b0};
    logic        m_pv  [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] m_hc  [3] = '{16'h0, 16'h0, 16'h0};
    logic [7:0]  m_st  [3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0]  wmask [3] = '{8'h01, 8'h0F, 8'hFF};
    logic [15:0] cmax  [3] = '{16'hFFFF, 16'h0003, 16'hFFFF};

    always #5 clk = ~clk;

`ifndef OR_GATE_STICKY_EN
    assign st1 = 1'b0;
    assign st4 = '0;
    assign st8 = '0;
`endif

    or_gate #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .x(xi[0]), .y(yi[0]), .z(zi[0]), .in_valid(vi),
`ifdef OR_GATE_STICKY_EN
        .sticky_clr(sticky_clr), .sticky(st1),
`endif
        .p(p1), .p_any(any1), .p_valid(pv1), .hit_count(hc1));

    or_gate #(.WIDTH(4), .CNT_W(2)) u4 (
        .clk(clk), .rst(rst), .x(xi[3:0]), .y(yi[3:0]), .z(zi[3:0]), .in_valid(vi),
`ifdef OR_GATE_STICKY_EN
        .sticky_clr(sticky_clr), .sticky(st4),
`endif
        .p(p4), .p_any(any4), .p_valid(pv4), .hit_count(hc4));

    or_gate #(.WIDTH(8), .CNT_W(16)) u8 (
        .clk(clk), .rst(rst), .x(xi), .y(yi), .z(zi), .in_valid(vi),
`ifdef OR_GATE_STICKY_EN
        .sticky_clr(sticky_clr), .sticky(st8),
`endif
        .p(p8), .p_any(any8), .p_valid(pv8), .hit_count(hc8));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Drive one cycle, push model results, then pop and compare after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic clr);
        logic [7:0] or_v;
        exp_t       e;
        exp_t       o [3];
        rst = r; vi = v; xi = a; yi = b; zi = c; sticky_clr = clr;
        for (int i = 0; i < 3; i++) begin
            or_v = (a | b | c) & wmask[i];
            if (r) begin
                m_p[i] = '0; m_any[i] = 1'b0; m_pv[i] = 1'b0; m_hc[i] = '0; m_st[i] = '0;
            end else begin
                m_pv[i] = v;
                if (v) begin
                    m_p[i]   = or_v;
                    m_any[i] = |or_v;
                    if (m_any[i] && m_hc[i] != cmax[i]) m_hc[i] = m_hc[i] + 16'd1;
                end
                if (clr)    m_st[i] = v ? or_v : 8'h00;
                else if (v) m_st[i] = m_st[i] | or_v;
            end
            e = '{p: m_p[i], any: m_any[i], pv: m_pv[i], hc: m_hc[i], st: m_st[i]};
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        o[0] = '{p: 8'(p1), any: any1, pv: pv1, hc: hc1,      st: 8'(st1)};
        o[1] = '{p: 8'(p4), any: any4, pv: pv4, hc: 16'(hc4), st: 8'(st4)};
        o[2] = '{p: p8,     any: any8, pv: pv8, hc: hc8,      st: st8};
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            chk($sformatf("u%0d_p", i),       16'(o[i].p),   16'(e.p));
            chk($sformatf("u%0d_p_any", i),   16'(o[i].any), 16'(e.any));
            chk($sformatf("u%0d_p_valid", i), 16'(o[i].pv),  16'(e.pv));
            chk($sformatf("u%0d_hit", i),     o[i].hc,       e.hc);
`ifdef OR_GATE_STICKY_EN
            chk($sformatf("u%0d_sticky", i),  16'(o[i].st),  16'(e.st));
`endif
        end
    endtask

    initial begin
        logic [7:0] kb;
        logic [1:0] hc_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        #2;
        // Reset with a valid sample present: reset wins.
        step(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 1'b1);
        chk("reset_p8", 16'(p8), 16'h0000);
        chk("reset_hc1", hc1, 16'h0000);

        // Truth table on the 1-bit instance, first accept right after reset.
        for (int k = 0; k < 8; k++) begin
            kb = 8'(k);
            step(1'b0, 1'b1, {7'b0, kb[2]}, {7'b0, kb[1]}, {7'b0, kb[0]}, 1'b0);
            chk("truth_p1", 16'(p1), (k != 0) ? 16'h1 : 16'h0);
        end
        chk("truth_hc1_end", hc1, 16'd7);
        chk("truth_hc4_sat", 16'(hc4), 16'd3);

        // Wide OR, then hold with in_valid low.
        step(1'b0, 1'b1, 8'h01, 8'h10, 8'h80, 1'b0);
        chk("wide_p8", 16'(p8), 16'h0091);
        chk("wide_any8", 16'(any8), 16'h1);
        step(1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0);
        chk("hold_p8", 16'(p8), 16'h0091);
        chk("hold_pv8", 16'(pv8), 16'h0);

        // Unknown operands with in_valid low must not disturb state.
        step(1'b0, 1'b0, 8'hxx, 8'hxx, 8'hxx, 1'b0);
        step(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);

        // Mid-stream reset, then normal accept.
        step(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
        chk("midrst_p1", 16'(p1), 16'h0);
        chk("midrst_hc8", hc8, 16'h0);
        step(1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
        chk("postrst_p1", 16'(p1), 16'h1);

        // Two-bit counter saturation.
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 1'b0);
            chk("sat_hc4", 16'(hc4), 16'(hc_tab[k]));
        end

        // Sticky accumulation and clear.
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 8'h04, 8'h00, 1'b0);
`ifdef OR_GATE_STICKY_EN
        chk("sticky_acc", 16'(st4), 16'h5);
`endif
        step(1'b0, 1'b1, 8'h00, 8'h00, 8'h08, 1'b1);
`ifdef OR_GATE_STICKY_EN
        chk("sticky_clr_acc", 16'(st4), 16'h8);
`endif
        step(1'b0, 1'b0, 8'h0F, 8'h00, 8'h00, 1'b1);
`ifdef OR_GATE_STICKY_EN
        chk("sticky_clr_idle", 16'(st4), 16'h0);
`endif
        step(1'b0, 1'b1, 8'h02, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h0F, 8'h00, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/or_gate.md
OR_GATE -- requirements
Module: or_gate

Interface
REQ-001 Parameter WIDTH, default 1, is the bit width of each data input and of p.
REQ-002 Parameter CNT_W, default 16, is the width of hit_count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 x  input  WIDTH  operand 0.
REQ-006 y  input  WIDTH  operand 1.
REQ-007 z  input  WIDTH  operand 2.
REQ-008 in_valid  input  1  operands valid this cycle.
REQ-009 p  output  WIDTH  registered bitwise OR of x, y and z.
REQ-010 p_any  output  1  registered reduction OR of (x|y|z).
REQ-011 p_valid  output  1  p and p_any updated by the previous cycle's valid input.
REQ-012 hit_count  output  CNT_W  saturating count of accepted samples with p_any=1.
REQ-013 sticky_clr  input  1  sticky clear; present only when OR_GATE_STICKY_EN is defined.
REQ-014 sticky  output  WIDTH  accumulated OR of all accepted samples; present only when OR_GATE_STICKY_EN is defined.

Function
REQ-015 A sample is accepted on a rising edge with in_valid=1 and rst=0.
REQ-016 On accept, p SHALL load x|y|z bitwise, with one-cycle latency.
REQ-017 On accept, p_any SHALL load 1 if any bit of x, y or z is 1, else 0.
REQ-018 Without accept, p and p_any SHALL hold their values.
REQ-019 p_valid SHALL equal in_valid registered by one cycle; it is never held.
REQ-020 hit_count SHALL increment by 1 on each accept whose p_any result is 1.
REQ-021 hit_count SHALL saturate at all-ones and not wrap.
REQ-022 Inputs are sampled only at the clock edge; there is no combinational path from inputs to outputs.
REQ-023 X or Z on operands while in_valid=0 SHALL NOT affect any state.

Reset
REQ-024 rst=1 at a rising edge SHALL set p=0, p_any=0, p_valid=0, hit_count=0 and sticky=0.
REQ-025 Reset SHALL have priority over accept and over sticky_clr in the same cycle.
REQ-026 The first accept is possible on the first edge after rst deasserts.

Configuration
REQ-027 With macro OR_GATE_STICKY_EN defined, sticky SHALL OR in (x|y|z) on every accept.
REQ-028 With OR_GATE_STICKY_EN defined and sticky_clr=1, sticky SHALL load the current accepted value, or 0 if there is no accept.
REQ-029 Without OR_GATE_STICKY_EN, the sticky_clr and sticky ports and their logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-030 The shared package or_gate_pkg SHALL hold the CNT_W default and the saturating-increment function.
REQ-031 The sub-module or_gate_satcnt SHALL implement the saturating hit counter; all other logic is flat in or_gate.

Verification
REQ-032 WIDTH=1, in_valid=1: apply xyz = 000, 001, 010, 011, 100, 101, 110, 111 in successive cycles -> p = 0, 1, 1, 1, 1, 1, 1, 1 one cycle later; hit_count ends at 7.
REQ-033 WIDTH=8: x=0x01, y=0x10, z=0x80 accepted -> p=0x91 and p_any=1 next cycle; then in_valid=0 with x=0xFF -> p stays 0x91 and p_valid=0.
REQ-034 CNT_W=2: five accepts with nonzero operands -> hit_count = 1, 2, 3, 3, 3.
REQ-035 Assert rst mid-stream with in_valid=1 and x=1 -> all outputs 0 after that edge; the next accept updates normally.
REQ-036 Sticky build, WIDTH=4: accept 0x1, then 0x4 -> sticky=0x5; sticky_clr with an accept of 0x8 -> sticky=0x8; sticky_clr with no accept -> sticky=0x0.
